// File: rtl/shift_seq.sv
// Iterative barrel shifter that walks five power-of-two stages, one per cycle.
// The result always appears six cycles after acceptance, whatever the shift amount or op.
module shift_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic [3:0]  i_alu_op,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [31:0] o_result,
  output logic        o_busy
);

  // state | meaning
  // IDLE  | ready for a new operation, outputs at rest
  // SHIFT | applying stage cnt (shift by 2^cnt when shamt[cnt] is set)
  // DONE  | result presented, waiting for the consumer handshake
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [2:0] LAST_STAGE = 3'd4;

  state_t      state;
  logic [31:0] work;
  logic [4:0]  shamt;
  logic [3:0]  op;
  logic [2:0]  cnt;
  logic [31:0] stage_next;
  logic        stage_en;

  logic unused_op_b;
  assign unused_op_b = ^i_op_b[31:5];

  // Only the sign of the captured operand is ever shifted in for SRA; work[31]
  // keeps that sign through every arithmetic stage.
  function automatic logic [31:0] stage_shift(input logic [31:0] w,
                                              input logic [3:0]  code,
                                              input logic [2:0]  k,
                                              input logic        en);
    logic [4:0]  amt;
    logic [31:0] r;
    amt = 5'd1 << k;
    r   = w;
    if (en) begin
      case (code)
        OP_SLL:  r = w << amt;
        OP_SRL:  r = w >> amt;
        OP_SRA:  r = 32'($signed(w) >>> amt);
        default: r = w;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    stage_en   = 1'b0;
    case (cnt)
      3'd0:    stage_en = shamt[0];
      3'd1:    stage_en = shamt[1];
      3'd2:    stage_en = shamt[2];
      3'd3:    stage_en = shamt[3];
      3'd4:    stage_en = shamt[4];
      default: stage_en = 1'b0;
    endcase
    stage_next = stage_shift(work, op, cnt, stage_en);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      work        <= '0;
      shamt       <= '0;
      op          <= '0;
      cnt         <= '0;
      o_req_ready <= 1'b1;
      o_res_valid <= 1'b0;
      o_result    <= '0;
      o_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            work        <= i_op_a;
            shamt       <= i_op_b[4:0];
            op          <= i_alu_op;
            cnt         <= '0;
            state       <= SHIFT;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
          end
        end
        SHIFT: begin
          work <= stage_next;
          cnt  <= cnt + 3'd1;
          if (cnt == LAST_STAGE) begin
            state       <= DONE;
            o_res_valid <= 1'b1;
            o_result    <= stage_next;
          end
        end
        DONE: begin
          if (i_res_ready) begin
            state       <= IDLE;
            o_res_valid <= 1'b0;
            o_result    <= '0;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_res_valid <= 1'b0;
          o_result    <= '0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Randomized and directed bench for shift_seq against a cycle-count transaction model.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  alu_op = '0;
  logic        req_ready, res_valid, busy;
  logic [31:0] result;

  shift_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_alu_op    (alu_op),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_result    (result),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] code);
    int sh;
    sh = int'(b % 32);
    case (code)
      4'b0111: return a << sh;
      4'b1000: return a >> sh;
      4'b1001: return 32'($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  // Transaction model: one pending op, result visible from six edges after acceptance.
  bit          pend = 1'b0;
  int          cyc = 0;
  int          start = 0;
  logic [31:0] exp_res = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cyc - start >= 6 && res_ready) pend = 1'b0;
      end else if (req_valid) begin
        pend    = 1'b1;
        start   = cyc;
        exp_res = ref_shift(op_a, op_b, alu_op);
      end
      cyc++;
    end
  end

  always @(posedge clk) begin
    bit v;
    #1;
    if (chk_en) begin
      v = pend && (cyc - start >= 6);
      check("model_req_ready", 32'(req_ready), 32'(!pend));
      check("model_busy", 32'(busy), 32'(pend));
      check("model_res_valid", 32'(res_valid), 32'(v));
      check("model_result", result, v ? exp_res : 32'h0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] code,
                       input logic [31:0] exp, input int hold, input bit garbage);
    int n;
    logic [31:0] held;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    op_a      = a;
    op_b      = b;
    alu_op    = code;
    res_ready = 1'b0;
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (garbage) begin
      op_a   = 32'hFFFF_FFFF;
      op_b   = 32'h0000_001F;
      alu_op = 4'b0111;
    end else begin
      req_valid = 1'b0;
    end
    n = 1;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd6);
    check("result", result, exp);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_result", result, held);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("after_handshake_ready", 32'(req_ready), 32'd1);
    check("after_handshake_busy", 32'(busy), 32'd0);
    if (garbage) begin
      @(negedge clk);
      check("second_accepted", 32'(busy), 32'd1);
      req_valid = 1'b0;
      drain();
    end
  endtask

  initial begin
    #12;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_op(32'h8000_0000, 32'd4,         4'b1001, 32'hF800_0000, 3, 1'b0);
    do_op(32'h8000_0000, 32'd31,        4'b1000, 32'h0000_0001, 0, 1'b0);
    do_op(32'h0000_0001, 32'h25,        4'b0111, 32'h0000_0020, 0, 1'b0);
    do_op(32'h1234_5678, 32'd7,         4'b0000, 32'h1234_5678, 0, 1'b0);
    do_op(32'h0000_0010, 32'd1,         4'b1000, 32'h0000_0008, 0, 1'b1);
    do_op(32'h8765_4321, 32'hFFFF_FFE0, 4'b1001, 32'h8765_4321, 1, 1'b0);
    do_op(32'hC000_0000, 32'h0000_0023, 4'b1001, 32'hF800_0000, 0, 1'b0);

    // abort during stage 2
    @(negedge clk);
    req_valid = 1'b1;
    op_a      = 32'hDEAD_BEEF;
    op_b      = 32'd9;
    alu_op    = 4'b0111;
    res_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_valid_after_abort", 32'(res_valid), 32'd0);
    end

    // request on the first edge after release
    rst_n = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b1;
    op_a      = 32'h0000_00F0;
    op_b      = 32'd4;
    alu_op    = 4'b1000;
    @(negedge clk);
    check("first_edge_accept", 32'(busy), 32'd1);
    req_valid = 1'b0;
    drain();
    check("first_edge_ready", 32'(req_ready), 32'd1);

    repeat (800) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      op_a      = $urandom;
      op_b      = $urandom;
      case ($urandom_range(0, 3))
        0:       alu_op = 4'b0111;
        1:       alu_op = 4'b1000;
        2:       alu_op = 4'b1001;
        default: alu_op = 4'($urandom_range(0, 15));
      endcase
      res_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning):
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req_valid  input  1  requester presents an operation.
REQ-005 o_req_ready  output  1  block accepts an operation this cycle.
REQ-006 i_op_a  input  32  operand to shift.
REQ-007 i_op_b  input  32  shift amount; only bits [4:0] used.
REQ-008 i_alu_op  input  4  operation: 4'b0111 SLL, 4'b1000 SRL, 4'b1001 SRA; any other code is pass-through.
REQ-009 o_res_valid  output  1  o_result is valid.
REQ-010 i_res_ready  input  1  consumer takes the result this cycle.
REQ-011 o_result  output  32  shift result.
REQ-012 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: o_req_ready=1, o_res_valid=0; on i_req_valid=1, capture i_op_a into the working register, i_op_b[4:0] into shamt, i_alu_op into op; clear stage counter to 0; go to SHIFT.
REQ-015 SHIFT: each cycle process stage k = counter (0..4) by amount 2^k if shamt[k]=1, else hold the working register; increment counter.
REQ-016 SLL stage: shift left by 2^k, fill zeros; SRL: shift right, fill zeros; SRA: shift right, fill with captured op_a[31].
REQ-017 Pass-through op: working register SHALL remain unchanged through all stages.
REQ-018 After stage 4 completes, go to DONE; latency SHALL be fixed: accept at cycle N, o_res_valid=1 at cycle N+6, independent of shamt and op.
REQ-019 DONE: o_res_valid=1; o_result = working register, held stable until handshake; on i_res_ready=1 go to IDLE the next cycle.
REQ-020 o_req_ready SHALL be 0 in SHIFT and DONE; i_req_valid in those states SHALL be ignored and SHALL NOT alter captured operands.
REQ-021 No back-to-back overlap: a new request SHALL be accepted no earlier than the cycle after the DONE handshake.
REQ-022 i_res_ready outside DONE SHALL have no effect.
REQ-023 i_op_b[31:5] SHALL have no effect on the result.
REQ-024 o_result SHALL read 0 in IDLE and SHIFT; it equals the working register only in DONE.

Reset
REQ-025 i_rst_n=0 SHALL immediately, without waiting for a clock, force state IDLE, working register 0, shamt 0, op 0, counter 0.
REQ-026 During and after reset: o_req_ready=1, o_res_valid=0, o_result=0, o_busy=0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no result is produced for it after release.
REQ-028 The first rising edge with i_rst_n=1 SHALL be able to accept a request.

Verification
REQ-029 SRA: op_a=0x80000000, op_b=4, op=1001, accepted cycle N -> o_res_valid=1 at N+6, o_result=0xF8000000.
REQ-030 SRL/SLL: op_a=0x80000000, op_b=31, op=1000 -> 0x00000001; op_a=0x00000001, op_b=0x25, op=0111 -> 0x00000020 (only bits [4:0] used).
REQ-031 Backpressure: hold i_res_ready=0 for 3 cycles in DONE -> o_res_valid and o_result stable, o_req_ready=0; i_res_ready=1 -> IDLE next cycle, o_req_ready=1.
REQ-032 Busy-ignore: drive i_req_valid=1 with op_a=0xFFFFFFFF during SHIFT of op_a=0x00000010, op_b=1, SRL -> result 0x00000008; second request accepted only after the DONE handshake.
REQ-033 Reset mid-operation: assert i_rst_n=0 at stage 2 -> outputs go to reset values asynchronously; after release no o_res_valid until a new request completes.
REQ-034 Pass-through: op=0000, op_a=0x12345678, op_b=7 -> o_result=0x12345678 at N+6.
